// File: rtl/strike_counter_pkg.sv
// strike_counter_pkg: shared game definitions for the strike counter slice.
//   state_e             - strike FSM states (ARMED, DETONATED, FROZEN)
//   COUNT_W             - width of the exported strike count
//   SUM_W               - width of the saturating add (no wrap for legal configs)
//   DEFAULT_MAX_STRIKES - default detonation threshold
package strike_counter_pkg;

  localparam int unsigned COUNT_W             = 3;
  localparam int unsigned SUM_W               = 4;
  localparam int unsigned DEFAULT_MAX_STRIKES = 3;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    DETONATED = 2'd1,
    FROZEN    = 2'd2
  } state_e;

endpackage

// File: rtl/strike_counter_if.sv
// strike_counter_if: bundle between the puzzle/game side and the strike counter.
//   mistake        - per-source mistake levels (NUM_SOURCES bits)
//   freeze         - game over, stops counting
//   strike_count   - current strikes, 0..MAX_STRIKES
//   strike_leds    - thermometer code of strike_count (MAX_STRIKES bits)
//   explode_strike - sticky detonation request
//   buzzer         - strike buzzer, only with STRIKE_COUNTER_BUZZER_EN
// master: game side driving mistakes/freeze; slave: the strike counter.
interface strike_counter_if
  import strike_counter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned MAX_STRIKES = DEFAULT_MAX_STRIKES
);

  logic [NUM_SOURCES-1:0] mistake;
  logic                   freeze;
  logic [COUNT_W-1:0]     strike_count;
  logic [MAX_STRIKES-1:0] strike_leds;
  logic                   explode_strike;
`ifdef STRIKE_COUNTER_BUZZER_EN
  logic                   buzzer;
`endif

  modport master (
`ifdef STRIKE_COUNTER_BUZZER_EN
    input  buzzer,
`endif
    output mistake,
    output freeze,
    input  strike_count,
    input  strike_leds,
    input  explode_strike
  );

  modport slave (
`ifdef STRIKE_COUNTER_BUZZER_EN
    output buzzer,
`endif
    input  mistake,
    input  freeze,
    output strike_count,
    output strike_leds,
    output explode_strike
  );

endinterface

// File: rtl/strike_counter_edge_rise.sv
// edge_rise: single-source rising-edge detector.
//   clock  - system clock
//   din    - mistake level from one puzzle module
//   rise_c - combinational strike pulse, din & ~prev
// prev samples din on every edge, reset included, so a level already high when
// reset releases never looks like a new edge. That makes an explicit reset
// branch unnecessary here.
module edge_rise (
  input  logic clock,
  input  logic din,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clock) begin
    prev <= din;
  end

  assign rise_c = din & ~prev;

endmodule

// File: rtl/strike_counter.sv
// strike_counter: counts puzzle mistakes as strikes and requests detonation at
// MAX_STRIKES.
//   clock - system clock
//   reset - synchronous, active-high
//   bus   - strike_counter_if.slave (mistake, freeze in; strike_count,
//           strike_leds, explode_strike, optional buzzer out)
// Optional feature: define STRIKE_COUNTER_BUZZER_EN to add the buzzer output,
// the BUZZ_CYCLES parameter and the buzzer down-counter.
module strike_counter
  import strike_counter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned MAX_STRIKES = DEFAULT_MAX_STRIKES
`ifdef STRIKE_COUNTER_BUZZER_EN
  ,
  parameter int unsigned BUZZ_CYCLES = 2_500_000
`endif
) (
  input logic             clock,
  input logic             reset,
  strike_counter_if.slave bus
);

  logic [NUM_SOURCES-1:0] rise_c;
  logic [SUM_W-1:0]       edge_cnt_c;
  logic [SUM_W-1:0]       sum_c;

  state_e                 state_q,    state_d;
  logic [COUNT_W-1:0]     count_q,    count_d;
  logic [MAX_STRIKES-1:0] leds_q,     leds_d;
  logic                   explode_q,  explode_d;

  // Per-source rising-edge detectors
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_edge
    edge_rise u_edge_rise (
      .clock  (clock),
      .din    (bus.mistake[i]),
      .rise_c (rise_c[i])
    );
  end

  // Popcount of this cycle's edges and the unsaturated candidate count
  always_comb begin
    edge_cnt_c = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      edge_cnt_c = edge_cnt_c + SUM_W'(rise_c[i]);
    end
    sum_c = SUM_W'(count_q) + edge_cnt_c;
  end

  // State/output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ARMED;
      count_q   <= '0;
      leds_q    <= '0;
      explode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      leds_q    <= leds_d;
      explode_q <= explode_d;
    end
  end

  // Next state: freeze wins over same-cycle edges; DETONATED/FROZEN are terminal
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    leds_d    = '0;
    explode_d = 1'b0;

    case (state_q)
      ARMED: begin
        if (bus.freeze) begin
          state_d = FROZEN;
        end else if (sum_c >= SUM_W'(MAX_STRIKES)) begin
          count_d = COUNT_W'(MAX_STRIKES);
          state_d = DETONATED;
        end else begin
          count_d = COUNT_W'(sum_c);
        end
      end
      DETONATED: ;
      FROZEN:    ;
      default:   state_d = ARMED;
    endcase

    for (int i = 0; i < MAX_STRIKES; i++) begin
      leds_d[i] = (count_d > COUNT_W'(i));
    end
    explode_d = (state_d == DETONATED);
  end

  assign bus.strike_count   = count_q;
  assign bus.strike_leds    = leds_q;
  assign bus.explode_strike = explode_q;

`ifdef STRIKE_COUNTER_BUZZER_EN
  localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  logic [BUZZ_W-1:0] buzz_q, buzz_d;
  logic              buzzer_q;

  // Any count increase (re)loads the full pulse; otherwise run down to zero
  always_comb begin
    buzz_d = buzz_q;
    if (count_d > count_q) begin
      buzz_d = BUZZ_W'(BUZZ_CYCLES);
    end else if (buzz_q != '0) begin
      buzz_d = buzz_q - BUZZ_W'(1);
    end
  end

  // buzzer_q tracks the next counter value so it rises with the count
  always_ff @(posedge clock) begin
    if (reset) begin
      buzz_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      buzz_q   <= buzz_d;
      buzzer_q <= (buzz_d != '0);
    end
  end

  assign bus.buzzer = buzzer_q;
`endif

endmodule

// File: tb/tb_strike_counter.sv
// tb_strike_counter: directed self-checking bench for strike_counter
// (NUM_SOURCES=4, MAX_STRIKES=3; BUZZ_CYCLES=8 when STRIKE_COUNTER_BUZZER_EN).
module tb_strike_counter;
  import strike_counter_pkg::*;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  strike_counter_if #(.NUM_SOURCES(4), .MAX_STRIKES(3)) bus ();

  strike_counter #(
    .NUM_SOURCES (4),
    .MAX_STRIKES (3)
`ifdef STRIKE_COUNTER_BUZZER_EN
    ,
    .BUZZ_CYCLES (8)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.mistake = 4'b0010;
    bus.freeze  = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.strike_count !== 3'd0) begin
      miscompares++; $display("FAIL reset_count got %0d exp 0", bus.strike_count);
    end
    vectors++;
    if (bus.strike_leds !== 3'b000) begin
      miscompares++; $display("FAIL reset_leds got %b exp 000", bus.strike_leds);
    end
    vectors++;
    if (bus.explode_strike !== 1'b0) begin
      miscompares++; $display("FAIL reset_explode got %b exp 0", bus.explode_strike);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (bus.strike_count !== 3'd0) begin
      miscompares++; $display("FAIL held_level_count got %0d exp 0", bus.strike_count);
    end
`ifdef STRIKE_COUNTER_BUZZER_EN
    vectors++;
    if (bus.buzzer !== 1'b0) begin
      miscompares++; $display("FAIL held_level_buzzer got %b exp 0", bus.buzzer);
    end
`endif
  endtask

  task automatic test_single_pulse();
    bus.mistake = 4'b0011;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd1) begin
      miscompares++; $display("FAIL pulse_count got %0d exp 1", bus.strike_count);
    end
    vectors++;
    if (bus.strike_leds !== 3'b001) begin
      miscompares++; $display("FAIL pulse_leds got %b exp 001", bus.strike_leds);
    end
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (bus.strike_count !== 3'd1) begin
      miscompares++; $display("FAIL hold_count got %0d exp 1", bus.strike_count);
    end
    bus.mistake = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    bus.mistake = 4'b1010;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd3) begin
      miscompares++; $display("FAIL simul_count got %0d exp 3", bus.strike_count);
    end
    vectors++;
    if (bus.strike_leds !== 3'b111) begin
      miscompares++; $display("FAIL simul_leds got %b exp 111", bus.strike_leds);
    end
    vectors++;
    if (bus.explode_strike !== 1'b1) begin
      miscompares++; $display("FAIL simul_explode got %b exp 1", bus.explode_strike);
    end
    bus.mistake = 4'b0000;
    tick();
    bus.mistake = 4'b0001;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd3 || bus.explode_strike !== 1'b1) begin
      miscompares++;
      $display("FAIL post_det got count %0d explode %b exp 3/1", bus.strike_count, bus.explode_strike);
    end
    bus.mistake = 4'b0000;
    tick();
  endtask

  task automatic test_reset_after_det();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.strike_count !== 3'd0 || bus.strike_leds !== 3'b000 || bus.explode_strike !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_reset got count %0d leds %b explode %b exp 0/000/0",
               bus.strike_count, bus.strike_leds, bus.explode_strike);
    end
    bus.mistake = 4'b0100;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd1) begin
      miscompares++; $display("FAIL rearm_count got %0d exp 1", bus.strike_count);
    end
  endtask

  task automatic test_freeze();
    bus.mistake = 4'b0000;
    tick();
    bus.mistake = 4'b0001;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd2) begin
      miscompares++; $display("FAIL freeze_setup got %0d exp 2", bus.strike_count);
    end
    bus.mistake = 4'b0000;
    tick();
    bus.freeze  = 1'b1;
    bus.mistake = 4'b0100;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd2 || bus.explode_strike !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze_block got count %0d explode %b exp 2/0", bus.strike_count, bus.explode_strike);
    end
    vectors++;
    if (bus.strike_leds !== 3'b011) begin
      miscompares++; $display("FAIL freeze_leds got %b exp 011", bus.strike_leds);
    end
    bus.freeze  = 1'b0;
    bus.mistake = 4'b0000;
    tick();
    bus.mistake = 4'b1001;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd2) begin
      miscompares++; $display("FAIL frozen_terminal got %0d exp 2", bus.strike_count);
    end
    bus.mistake = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      bus.mistake = 4'b1000;
      tick();
      vectors++;
      if (bus.strike_count !== 3'(s)) begin
        miscompares++; $display("FAIL b2b_count step %0d got %0d exp %0d", s, bus.strike_count, s);
      end
      bus.mistake = 4'b0000;
      tick();
    end
    vectors++;
    if (bus.explode_strike !== 1'b1) begin
      miscompares++; $display("FAIL b2b_explode got %b exp 1", bus.explode_strike);
    end
  endtask

  task automatic test_saturate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mistake = 4'b1111;
    tick();
    vectors++;
    if (bus.strike_count !== 3'd3 || bus.explode_strike !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate got count %0d explode %b exp 3/1", bus.strike_count, bus.explode_strike);
    end
    bus.mistake = 4'b0000;
    tick();
  endtask

`ifdef STRIKE_COUNTER_BUZZER_EN
  task automatic test_buzzer();
    logic exp_buzz;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // cyc labels the cycle in which mistake is applied; sample is cycle cyc+1
    for (int cyc = 0; cyc < 26; cyc++) begin
      bus.mistake = (cyc == 10) ? 4'b0001 : (cyc == 14) ? 4'b0010 : 4'b0000;
      tick();
      exp_buzz = (cyc + 1 >= 11) && (cyc + 1 <= 22);
      vectors++;
      if (bus.buzzer !== exp_buzz) begin
        miscompares++; $display("FAIL buzzer cycle %0d got %b exp %b", cyc + 1, bus.buzzer, exp_buzz);
      end
    end
    vectors++;
    if (bus.strike_count !== 3'd2) begin
      miscompares++; $display("FAIL buzzer_count got %0d exp 2", bus.strike_count);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.mistake = '0;
    bus.freeze  = 1'b0;
    test_reset();
    test_single_pulse();
    test_simultaneous();
    test_reset_after_det();
    test_freeze();
    test_back_to_back();
    test_saturate();
`ifdef STRIKE_COUNTER_BUZZER_EN
    test_buzzer();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
